// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: measures line/frame periods from incoming syncs, regenerates
// pixel coordinates and an active-video flag, and declares lock after consecutive matching frames.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned H_OFFSET        = 144,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned V_OFFSET        = 35,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned LOCK_FRAMES     = 2
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
  output logic        active_video,
  output logic [15:0] h_period,
  output logic [15:0] v_period,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_error
);

  localparam logic [15:0] HTotal   = 16'(H_TOTAL);
  localparam logic [15:0] HStart   = 16'(H_OFFSET);
  localparam logic [15:0] HEnd     = 16'(H_OFFSET + H_ACTIVE);
  localparam logic [15:0] VTotal   = 16'(V_TOTAL);
  localparam logic [15:0] VStart   = 16'(V_OFFSET);
  localparam logic [15:0] VEnd     = 16'(V_OFFSET + V_ACTIVE);
  localparam logic [15:0] HTimeout = 16'(2 * H_TOTAL);
  localparam logic [15:0] CntMax   = 16'hFFFF;
  localparam int unsigned MatchW   = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [MatchW-1:0] LockLast = MatchW'(LOCK_FRAMES - 1);
  localparam logic Pol = (SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

  logic              hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic [15:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [15:0]       h_period_q, h_period_d, v_period_q, v_period_d;
  logic [15:0]       x_q, x_d, y_q, y_d;
  logic              av_q, av_d, fs_q, err_q, err_d, bad_line_q, bad_line_d;
  logic [MatchW-1:0] match_q, match_d;
  state_e            state_q, state_d;

  logic        hs_edge, vs_edge, h_bad, frame_bad, timeout;
  logic [15:0] h_meas, v_meas;

  always_comb begin
    hs_edge   = hs_q & ~hs_prev_q;
    vs_edge   = vs_q & ~vs_prev_q;
    h_meas    = (h_cnt_q == CntMax) ? CntMax : h_cnt_q + 16'd1;
    // A same-cycle hsync edge closes the last line of the frame that vsync is ending.
    v_meas    = (hs_edge && v_cnt_q != CntMax) ? v_cnt_q + 16'd1 : v_cnt_q;
    h_bad     = hs_edge & (h_meas != HTotal);
    frame_bad = bad_line_q | h_bad;
    timeout   = ~hs_edge & (h_cnt_q == HTimeout);

    h_cnt_d    = hs_edge ? 16'd0 : ((h_cnt_q == CntMax) ? CntMax : h_cnt_q + 16'd1);
    v_cnt_d    = vs_edge ? 16'd0 : v_meas;
    h_period_d = hs_edge ? h_meas : h_period_q;
    v_period_d = vs_edge ? v_meas : v_period_q;
    bad_line_d = vs_edge ? 1'b0 : frame_bad;

    av_d = (h_cnt_q >= HStart) && (h_cnt_q < HEnd) && (v_cnt_q >= VStart) && (v_cnt_q < VEnd);
    x_d  = av_d ? h_cnt_q - HStart : 16'd0;
    y_d  = av_d ? v_cnt_q - VStart : 16'd0;
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    err_d   = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (vs_edge) begin
          state_d = StCheck;
          match_d = '0;
        end
      end
      StCheck: begin
        if (vs_edge) begin
          if (v_meas == VTotal && !frame_bad) begin
            if (match_q == LockLast) begin
              state_d = StLocked;
              match_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
      end
      StLocked: begin
        if (h_bad || (vs_edge && v_meas != VTotal)) begin
          err_d   = 1'b1;
          state_d = StSearch;
          match_d = '0;
        end
      end
      default: state_d = StSearch;
    endcase
    // Loss of hsync overrides everything; equality fires once since h_cnt then keeps counting.
    if (timeout) begin
      err_d   = (state_q == StLocked);
      state_d = StSearch;
      match_d = '0;
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      hs_q       <= 1'b0;
      hs_prev_q  <= 1'b0;
      vs_q       <= 1'b0;
      vs_prev_q  <= 1'b0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      h_period_q <= '0;
      v_period_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      av_q       <= 1'b0;
      fs_q       <= 1'b0;
      err_q      <= 1'b0;
      bad_line_q <= 1'b0;
      match_q    <= '0;
      state_q    <= StSearch;
    end else begin
      hs_q       <= hsync_in ^ Pol;
      hs_prev_q  <= hs_q;
      vs_q       <= vsync_in ^ Pol;
      vs_prev_q  <= vs_q;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      h_period_q <= h_period_d;
      v_period_q <= v_period_d;
      x_q        <= x_d;
      y_q        <= y_d;
      av_q       <= av_d;
      fs_q       <= vs_edge;
      err_q      <= err_d;
      bad_line_q <= bad_line_d;
      match_q    <= match_d;
      state_q    <= state_d;
    end
  end

  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign active_video = av_q;
  assign h_period     = h_period_q;
  assign v_period     = v_period_q;
  assign frame_start  = fs_q;
  assign sync_error   = err_q;
  assign locked       = (state_q == StLocked);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder using a reduced timing mode so many frames fit in a run.
module tb_vga_sync_decoder;

  localparam int H = 40, HOFF = 8, HACT = 24, V = 20, VOFF = 3, VACT = 14;
  localparam int HSW = 4, VSW = 2, LF = 2;

  logic        clk = 1'b0, rst = 1'b1, hs = 1'b1, vs = 1'b1;
  logic [15:0] x_pos, y_pos, h_period, v_period;
  logic        av, fs, lk, se;

  vga_sync_decoder #(
    .H_TOTAL(H), .H_OFFSET(HOFF), .H_ACTIVE(HACT), .V_TOTAL(V), .V_OFFSET(VOFF),
    .V_ACTIVE(VACT), .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LF)
  ) dut (
    .clk_25MHz(clk), .reset(rst), .hsync_in(hs), .vsync_in(vs),
    .x_pos(x_pos), .y_pos(y_pos), .active_video(av), .h_period(h_period),
    .v_period(v_period), .frame_start(fs), .locked(lk), .sync_error(se)
  );

  always #5 clk = ~clk;

  typedef struct {longint clkn; bit chk; bit zero; bit av; int x; int y;} coord_t;
  typedef struct {longint clkn; int vper; int hper; bit lk;} frame_t;

  coord_t cq[$];
  frame_t fq[$];
  longint eq[$];

  int     total = 0, bad = 0;
  longint cyc = 0, drv_clk = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: run of clean frames since the last break, and stream bookkeeping.
  int     m_run = 0, m_lines = 0, last_lp = 0, last_ln = 0;
  bit     m_armed = 0, m_fbad = 0, m_lunk = 1, coord_ok = 0;
  longint last_hedge = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_break();
    m_run   = 0;
    m_armed = 0;
  endtask

  task automatic model_reset();
    model_break();
    m_lines  = 0;
    m_lunk   = 1;
    m_fbad   = 0;
    coord_ok = 0;
  endtask

  // Called at every hsync pin edge P; the measured period is simply the gap between pin edges.
  task automatic model_hedge(input bit is_v, input longint p);
    int     l;
    bit     lbad, was_lk, err;
    frame_t f;
    l      = int'(p - last_hedge);
    lbad   = m_lunk || (l != H);
    was_lk = (m_run >= LF);
    m_lines++;
    err = was_lk && (lbad || (is_v && m_lines != V));
    if (err) begin
      eq.push_back(p + 1);
      model_break();
    end
    if (is_v) begin
      if (!err) begin
        if (!m_armed) begin
          m_armed = 1;
          m_run   = 0;
        end else if (!was_lk) begin
          m_run = (!m_fbad && !lbad && m_lines == V) ? m_run + 1 : 0;
        end
      end
      f.clkn = p + 1;
      f.vper = m_lines;
      f.hper = m_lunk ? -1 : l;
      f.lk   = (m_run >= LF);
      fq.push_back(f);
      m_lines = 0;
      m_fbad  = 0;
    end else begin
      m_fbad = m_fbad | lbad;
    end
    m_lunk     = 0;
    last_hedge = p;
  endtask

  // Drive one clock's pins (asserted = low) and queue the output expected after that clock.
  task automatic tick(input bit h_as, input bit v_as, input bit r, input int lp, input int ln);
    coord_t c;
    int     k;
    @(negedge clk);
    rst = r;
    hs  = ~h_as;
    vs  = ~v_as;
    drv_clk = cyc + 1;
    if (r) coord_ok = 0;
    else if (ln == 0 && lp == 2) coord_ok = 1;
    k      = lp - 2;
    c.clkn = drv_clk;
    c.zero = r;
    c.chk  = coord_ok && !r;
    c.av   = (k >= HOFF) && (k < HOFF + HACT) && (ln >= VOFF) && (ln < VOFF + VACT);
    c.x    = c.av ? k - HOFF : 0;
    c.y    = c.av ? ln - VOFF : 0;
    cq.push_back(c);
  endtask

  task automatic send_line(input int len, input int ln, input int rst_lp);
    for (int lp = 0; lp < len; lp++) begin
      tick(lp < HSW, ln < VSW, lp == rst_lp, lp, ln);
      if (lp == 0) model_hedge(ln == 0, drv_clk);
      if (lp == rst_lp) model_reset();
      last_lp = lp;
      last_ln = ln;
    end
  endtask

  task automatic send_frame(input int n, input int short_ln, input int rst_ln);
    for (int ln = 0; ln < n; ln++)
      send_line((ln == short_ln) ? H - 1 : H, ln, (ln == rst_ln) ? 20 : -1);
  endtask

  task automatic send_random_frame();
    int n, len;
    n = V;
    if ($urandom_range(0, 3) == 0) n = V - 1 + 2 * int'($urandom_range(0, 1));
    for (int ln = 0; ln < n; ln++) begin
      len = H;
      if ($urandom_range(0, 29) == 0) len = H - 1 + 2 * int'($urandom_range(0, 1));
      send_line(len, ln, -1);
    end
  endtask

  // Both syncs deasserted; the timeout fires 2*H clocks after the last hsync edge commits.
  task automatic idle(input int n);
    int lp0;
    lp0 = last_lp;
    if (m_run >= LF) eq.push_back(last_hedge + 2 + 2 * H);
    model_break();
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'b0, lp0 + 1 + i, last_ln);
      last_lp = lp0 + 1 + i;
    end
  endtask

  initial begin : monitor
    coord_t c;
    frame_t f;
    longint e;
    forever begin
      @(posedge clk);
      #1;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        if (c.zero)
          check("reset_zero", {x_pos, y_pos, h_period, v_period, av, fs, lk, se}, '0);
        else if (c.chk)
          check("coord", {av, x_pos, y_pos}, {c.av, 16'(c.x), 16'(c.y)});
      end
      if (se === 1'b1) begin
        if (eq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sync_error cycle=%0d got=1 want=0", cyc);
        end else begin
          e = eq.pop_front();
          check("sync_error_time", cyc, e);
          check("locked_on_error", lk, 1'b0);
        end
      end
      if (fs === 1'b1) begin
        if (fq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame_start cycle=%0d got=1 want=0", cyc);
        end else begin
          f = fq.pop_front();
          check("frame_start_time", cyc, f.clkn);
          check("v_period", v_period, 16'(f.vper));
          check("locked_at_vsync", lk, f.lk);
          if (f.hper >= 0) check("h_period", h_period, 16'(f.hper));
        end
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 100, V - 1);
    model_reset();
    repeat (5) send_frame(V, -1, -1);
    send_frame(V, 7, -1);
    repeat (4) send_frame(V, -1, -1);
    send_frame(V - 1, -1, -1);
    repeat (4) send_frame(V, -1, -1);
    idle(200);
    repeat (4) send_frame(V, -1, -1);
    send_frame(V, -1, 5);
    repeat (4) send_frame(V, -1, -1);
    repeat (10) send_random_frame();
    repeat (4) send_frame(V, -1, -1);
    send_line(H, 0, -1);
    send_line(H, 1, -1);
    repeat (4) @(negedge clk);
    check("pending_errors", eq.size(), 0);
    check("pending_frames", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
